// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared op-codes, condition codes, flag positions and pipeline register types
package cpu_pkg;

  localparam logic [2:0] ALU_SUMA     = 3'b000;
  localparam logic [2:0] ALU_RESTA    = 3'b001;
  localparam logic [2:0] ALU_MULT     = 3'b010;
  localparam logic [2:0] ALU_MODULO   = 3'b011;
  localparam logic [2:0] ALU_DESP_DER = 3'b100;
  localparam logic [2:0] ALU_PASA_B   = 3'b101;
  localparam logic [2:0] ALU_PASA_A   = 3'b110;

  localparam logic [2:0] COND_SIEMPRE = 3'b000;
  localparam logic [2:0] COND_Z       = 3'b001;
  localparam logic [2:0] COND_NZ      = 3'b010;
  localparam logic [2:0] COND_LT      = 3'b011;
  localparam logic [2:0] COND_GE      = 3'b100;
  localparam logic [2:0] COND_C       = 3'b101;
  localparam logic [2:0] COND_NC      = 3'b110;
  localparam logic [2:0] COND_NUNCA   = 3'b111;

  // Bit positions inside the {N, Z, V, C} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  // Control half of ID/EX; operands and indices are width-parameterised and live beside it
  typedef struct packed {
    logic       valido;
    logic       escribe;
    logic       banderas;
    logic       salto;
    logic [2:0] sel;
    logic [2:0] cond;
  } idex_ctrl_t;

  // Control half of EX/MEM
  typedef struct packed {
    logic valido;
    logic escribe;
    logic salto_tomado;
  } exmem_ctrl_t;

endpackage

// File: rtl/UnidadLogicoAritmetica.sv
// rtl/UnidadLogicoAritmetica.sv - ALU with {N, Z, V, C} flag outputs
module UnidadLogicoAritmetica #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [2:0]   i_sel,
  output logic [N-1:0] o_resultado,
  output logic [3:0]   o_banderas
);
  import cpu_pkg::*;

  logic [N:0]   w_suma;
  logic [N:0]   w_resta;
  logic [N-1:0] w_prod;
  logic [N-1:0] w_res;
  logic         w_c;
  logic         w_v;

  assign w_suma  = {1'b0, i_a} + {1'b0, i_b};
  // Subtraction as a + ~b + 1, so C=1 means no borrow
  assign w_resta = {1'b0, i_a} + {1'b0, ~i_b} + {{N{1'b0}}, 1'b1};
  assign w_prod  = i_a * i_b;

  // Operation select; carry and overflow are only meaningful for add/sub
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (i_sel)
      ALU_SUMA: begin
        w_res = w_suma[N-1:0];
        w_c   = w_suma[N];
        w_v   = (i_a[N-1] == i_b[N-1]) && (w_suma[N-1] != i_a[N-1]);
      end
      ALU_RESTA: begin
        w_res = w_resta[N-1:0];
        w_c   = w_resta[N];
        w_v   = (i_a[N-1] != i_b[N-1]) && (w_resta[N-1] != i_a[N-1]);
      end
      ALU_MULT:     w_res = w_prod;
      ALU_MODULO:   w_res = (i_b == '0) ? '0 : (i_a % i_b);
      ALU_DESP_DER: w_res = i_a >> i_b;
      ALU_PASA_B:   w_res = i_b;
      ALU_PASA_A:   w_res = i_a;
      default:      w_res = '0;
    endcase
  end

  assign o_resultado = w_res;
  assign o_banderas  = {w_res[N-1], (w_res == '0), w_v, w_c};

endmodule

// File: rtl/evaluador_condicion.sv
// rtl/evaluador_condicion.sv - maps condition code and current flags to cond_ok
module evaluador_condicion (
  input  logic [2:0] i_cond,
  input  logic [3:0] i_banderas,
  output logic       o_cond_ok
);
  import cpu_pkg::*;

  logic w_n, w_z, w_v, w_c;

  assign w_n = i_banderas[FLAG_N];
  assign w_z = i_banderas[FLAG_Z];
  assign w_v = i_banderas[FLAG_V];
  assign w_c = i_banderas[FLAG_C];

  // Condition decode against the architectural flags
  always_comb begin
    o_cond_ok = 1'b0;
    case (i_cond)
      COND_SIEMPRE: o_cond_ok = 1'b1;
      COND_Z:       o_cond_ok = w_z;
      COND_NZ:      o_cond_ok = !w_z;
      COND_LT:      o_cond_ok = w_n ^ w_v;
      COND_GE:      o_cond_ok = !(w_n ^ w_v);
      COND_C:       o_cond_ok = w_c;
      COND_NC:      o_cond_ok = !w_c;
      COND_NUNCA:   o_cond_ok = 1'b0;
      default:      o_cond_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/etapa_ejecucion.sv
// rtl/etapa_ejecucion.sv - execute stage: ID/EX, forwarding, ALU, flags, condition, EX/MEM
module etapa_ejecucion #(
  parameter int N = 32,
  parameter int R = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_stall,
  input  logic         i_flush,
  input  logic         i_id_valido,
  input  logic [N-1:0] i_id_opA,
  input  logic [N-1:0] i_id_opB,
  input  logic [R-1:0] i_id_rs1,
  input  logic [R-1:0] i_id_rs2,
  input  logic [R-1:0] i_id_rd,
  input  logic [2:0]   i_id_sel,
  input  logic         i_id_escribe,
  input  logic         i_id_banderas,
  input  logic         i_id_salto,
  input  logic [2:0]   i_id_cond,
  input  logic         i_wb_escribe,
  input  logic [R-1:0] i_wb_rd,
  input  logic [N-1:0] i_wb_resultado,
  output logic         o_ex_valido,
  output logic [N-1:0] o_ex_resultado,
  output logic [R-1:0] o_ex_rd,
  output logic         o_ex_escribe,
  output logic         o_ex_salto_tomado,
  output logic [3:0]   o_banderas
);
  import cpu_pkg::*;

  idex_ctrl_t  r_idex;
  logic [N-1:0] r_opa, r_opb;
  logic [R-1:0] r_rs1, r_rs2, r_rd;
  exmem_ctrl_t r_exmem;
  logic [N-1:0] r_ex_resultado;
  logic [R-1:0] r_ex_rd;
  logic [3:0]   r_banderas;

  logic [N-1:0] w_a, w_b, w_alu_res;
  logic [3:0]   w_alu_ban;
  logic         w_cond_ok;

  // Forwarding: EX/MEM (already gated by valid and cond) beats WB beats the ID/EX copy
  assign w_a = (r_exmem.escribe && r_ex_rd == r_rs1) ? r_ex_resultado :
               (i_wb_escribe && i_wb_rd == r_rs1)    ? i_wb_resultado : r_opa;
  assign w_b = (r_exmem.escribe && r_ex_rd == r_rs2) ? r_ex_resultado :
               (i_wb_escribe && i_wb_rd == r_rs2)    ? i_wb_resultado : r_opb;

  UnidadLogicoAritmetica #(.N(N)) u_alu (
    .i_a         (w_a),
    .i_b         (w_b),
    .i_sel       (r_idex.sel),
    .o_resultado (w_alu_res),
    .o_banderas  (w_alu_ban)
  );

  evaluador_condicion u_cond (
    .i_cond     (r_idex.cond),
    .i_banderas (r_banderas),
    .o_cond_ok  (w_cond_ok)
  );

  // ID/EX register: flush inserts a bubble even while stalled
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idex <= '0;
      r_opa  <= '0;
      r_opb  <= '0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_rd   <= '0;
    end else if (i_flush) begin
      r_idex <= '0;
    end else if (!i_stall) begin
      r_idex <= '{valido: i_id_valido, escribe: i_id_escribe, banderas: i_id_banderas,
                  salto: i_id_salto, sel: i_id_sel, cond: i_id_cond};
      r_opa  <= i_id_opA;
      r_opb  <= i_id_opB;
      r_rs1  <= i_id_rs1;
      r_rs2  <= i_id_rs2;
      r_rd   <= i_id_rd;
    end
  end

  // EX/MEM register: a bubble or a failed condition suppresses write and branch
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_exmem        <= '0;
      r_ex_resultado <= '0;
      r_ex_rd        <= '0;
    end else if (!i_stall) begin
      r_exmem.valido       <= r_idex.valido;
      r_exmem.escribe      <= r_idex.valido & r_idex.escribe & w_cond_ok;
      r_exmem.salto_tomado <= r_idex.valido & r_idex.salto & w_cond_ok;
      r_ex_resultado       <= w_alu_res;
      r_ex_rd              <= r_rd;
    end
  end

  // Flag register: the next instruction in EX reads it directly, no bypass needed
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_banderas <= '0;
    end else if (!i_stall && r_idex.valido && r_idex.banderas && w_cond_ok) begin
      r_banderas <= w_alu_ban;
    end
  end

  assign o_ex_valido       = r_exmem.valido;
  assign o_ex_escribe      = r_exmem.escribe;
  assign o_ex_salto_tomado = r_exmem.salto_tomado;
  assign o_ex_resultado    = r_ex_resultado;
  assign o_ex_rd           = r_ex_rd;
  assign o_banderas        = r_banderas;

endmodule

// File: tb/tb_etapa_ejecucion.sv
// tb/tb_etapa_ejecucion.sv - directed and random checks of the execute stage
module tb_etapa_ejecucion;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        id_valido, id_esc, id_ban, id_salto;
  logic [31:0] id_a, id_b;
  logic [3:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_sel, id_cond;
  logic        wb_esc;
  logic [3:0]  wb_rd;
  logic [31:0] wb_res;
  logic        ex_valido, ex_esc, ex_tk;
  logic [31:0] ex_res;
  logic [3:0]  ex_rd, ban;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  etapa_ejecucion #(.N(32), .R(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush),
    .i_id_valido(id_valido), .i_id_opA(id_a), .i_id_opB(id_b),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd), .i_id_sel(id_sel),
    .i_id_escribe(id_esc), .i_id_banderas(id_ban), .i_id_salto(id_salto), .i_id_cond(id_cond),
    .i_wb_escribe(wb_esc), .i_wb_rd(wb_rd), .i_wb_resultado(wb_res),
    .o_ex_valido(ex_valido), .o_ex_resultado(ex_res), .o_ex_rd(ex_rd),
    .o_ex_escribe(ex_esc), .o_ex_salto_tomado(ex_tk), .o_banderas(ban)
  );

  // Reference model: one instruction in EX, one result in EX/MEM, the four flags
  typedef struct {
    bit v; bit esc; bit ban; bit sal;
    logic [31:0] a; logic [31:0] b;
    logic [3:0] s1; logic [3:0] s2; logic [3:0] d;
    logic [2:0] sel; logic [2:0] cond;
  } ins_t;

  ins_t        m_ex;
  bit          mm_v, mm_esc, mm_tk;
  logic [31:0] mm_res;
  logic [3:0]  mm_rd;
  bit          fn, fz, fv, fc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit sat32(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // ALU result and flags from plain arithmetic
  function automatic logic [35:0] alu_ref(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    bit c, v;
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    c = 0; v = 0;
    case (sel)
      3'd0: begin r = a + b; c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF; v = sat32(sa + sb); end
      3'd1: begin r = a - b; c = (a >= b); v = sat32(sa - sb); end
      3'd2: r = a * b;
      3'd3: r = (b == 0) ? 32'd0 : a % b;
      3'd4: r = a >> b;
      3'd5: r = b;
      3'd6: r = a;
      default: r = 32'd0;
    endcase
    return {r[31], r == 32'd0, v, c, r};
  endfunction

  function automatic bit cond_ref(input logic [2:0] cond);
    case (cond)
      3'd0: return 1;
      3'd1: return fz;
      3'd2: return !fz;
      3'd3: return fn != fv;
      3'd4: return fn == fv;
      3'd5: return fc;
      3'd6: return !fc;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [3:0] s, input logic [31:0] regv);
    if (mm_esc && mm_rd == s) return mm_res;
    if (wb_esc && wb_rd == s) return wb_res;
    return regv;
  endfunction

  task automatic model_edge();
    logic [35:0] o;
    bit ok;
    if (rst) begin
      m_ex = '{default: 0};
      mm_v = 0; mm_esc = 0; mm_tk = 0; mm_res = 0; mm_rd = 0;
      fn = 0; fz = 0; fv = 0; fc = 0;
      return;
    end
    if (!stall) begin
      ok = cond_ref(m_ex.cond);
      o = alu_ref(m_ex.sel, fwd(m_ex.s1, m_ex.a), fwd(m_ex.s2, m_ex.b));
      if (m_ex.v && m_ex.ban && ok) {fn, fz, fv, fc} = o[35:32];
      mm_v = m_ex.v; mm_esc = m_ex.v && m_ex.esc && ok; mm_tk = m_ex.v && m_ex.sal && ok;
      mm_res = o[31:0]; mm_rd = m_ex.d;
    end
    if (flush) m_ex = '{default: 0};
    else if (!stall)
      m_ex = '{v: id_valido, esc: id_esc, ban: id_ban, sal: id_salto, a: id_a, b: id_b,
               s1: id_rs1, s2: id_rs2, d: id_rd, sel: id_sel, cond: id_cond};
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("valido", 32'(ex_valido), 32'(mm_v));
    chk("escribe", 32'(ex_esc), 32'(mm_esc));
    chk("salto_tomado", 32'(ex_tk), 32'(mm_tk));
    chk("banderas", 32'(ban), 32'({fn, fz, fv, fc}));
    if (mm_v) begin
      chk("resultado", ex_res, mm_res);
      chk("rd", 32'(ex_rd), 32'(mm_rd));
    end
  endtask

  task automatic set_ins(input bit v, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                         input logic [2:0] sel, input bit esc, input bit bn, input bit sal,
                         input logic [2:0] cond);
    id_valido = v; id_a = a; id_b = b; id_rs1 = s1; id_rs2 = s2; id_rd = d;
    id_sel = sel; id_esc = esc; id_ban = bn; id_salto = sal; id_cond = cond;
  endtask

  task automatic nop();
    set_ins(0, 0, 0, 4'd15, 4'd15, 4'd15, 3'd0, 0, 0, 0, 3'd0);
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0;
    wb_esc = 0; wb_rd = 0; wb_res = 0;
    nop();
    tick();
    chk("reset_valido", 32'(ex_valido), 0);
    chk("reset_resultado", ex_res, 0);
    chk("reset_banderas", 32'(ban), 0);
    rst = 0;

    // sum then subtract-to-zero
    set_ins(1, 5, 7, 4'd1, 4'd2, 4'd1, 3'b000, 1, 1, 0, 3'b000); tick();
    nop(); tick();
    chk("suma_res", ex_res, 12);
    chk("suma_ban", 32'(ban), 0);
    set_ins(1, 5, 5, 4'd5, 4'd6, 4'd7, 3'b001, 1, 1, 0, 3'b000); tick();
    nop(); tick();
    chk("resta_z", 32'(ban[2]), 1);

    // EX forwarding, then WB-only forwarding
    set_ins(1, 2, 2, 4'd8, 4'd9, 4'd3, 3'b000, 1, 0, 0, 3'b000); tick();
    set_ins(1, 0, 1, 4'd3, 4'd10, 4'd4, 3'b000, 1, 0, 0, 3'b000); tick();
    nop(); tick();
    chk("fwd_ex", ex_res, 5);
    wb_esc = 1; wb_rd = 3; wb_res = 9;
    set_ins(1, 0, 1, 4'd3, 4'd10, 4'd4, 3'b000, 1, 0, 0, 3'b000); tick();
    nop(); tick();
    chk("fwd_wb", ex_res, 10);
    wb_esc = 0;

    // conditional execution with Z=1
    set_ins(1, 3, 0, 4'd11, 4'd12, 4'd2, 3'b110, 1, 1, 0, 3'b010); tick();
    nop(); tick();
    chk("cond_nz_esc", 32'(ex_esc), 0);
    chk("cond_nz_ban", 32'(ban[2]), 1);
    set_ins(1, 3, 0, 4'd11, 4'd12, 4'd2, 3'b110, 1, 1, 0, 3'b001); tick();
    nop(); tick();
    chk("cond_z_esc", 32'(ex_esc), 1);

    // branch on N^V, flags produced by the immediately preceding instruction
    set_ins(1, 0, 32'h8000_0000, 4'd11, 4'd12, 4'd13, 3'b101, 0, 1, 0, 3'b000); tick();
    set_ins(1, 0, 0, 4'd11, 4'd12, 4'd13, 3'b110, 0, 0, 1, 3'b011); tick();
    nop(); tick();
    chk("br_lt_taken", 32'(ex_tk), 1);
    tick();
    chk("br_one_cycle", 32'(ex_tk), 0);
    set_ins(1, 32'h7FFF_FFFF, 1, 4'd11, 4'd12, 4'd13, 3'b000, 0, 1, 0, 3'b000); tick();
    set_ins(1, 0, 0, 4'd11, 4'd12, 4'd13, 3'b110, 0, 0, 1, 3'b011); tick();
    nop(); tick();
    chk("br_nv_ban", 32'(ban), 32'b1010);
    chk("br_nv_not", 32'(ex_tk), 0);

    // stall held three cycles
    set_ins(1, 11, 22, 4'd1, 4'd2, 4'd5, 3'b000, 1, 1, 0, 3'b000); tick();
    nop(); tick();
    set_ins(1, 1, 1, 4'd6, 4'd7, 4'd9, 3'b000, 1, 0, 0, 3'b000);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_res", ex_res, 33);
      chk("stall_valido", 32'(ex_valido), 1);
      chk("stall_ban", 32'(ban), 0);
    end
    stall = 0; tick();
    nop(); tick();
    chk("post_stall_res", ex_res, 2);

    // stall and flush together
    set_ins(1, 3, 4, 4'd1, 4'd2, 4'd8, 3'b000, 1, 0, 0, 3'b000); tick();
    set_ins(1, 6, 6, 4'd1, 4'd2, 4'd8, 3'b000, 1, 0, 0, 3'b000);
    stall = 1; flush = 1; tick();
    stall = 0; flush = 0; nop(); tick();
    chk("flush_bubble", 32'(ex_valido), 0);

    // reset with two instructions in flight
    set_ins(1, 1, 2, 4'd1, 4'd2, 4'd3, 3'b000, 1, 1, 1, 3'b000); tick();
    set_ins(1, 4, 5, 4'd1, 4'd2, 4'd3, 3'b000, 1, 1, 1, 3'b000); tick();
    rst = 1; nop(); tick();
    chk("rst_valido", 32'(ex_valido), 0);
    chk("rst_res", ex_res, 0);
    chk("rst_rd", 32'(ex_rd), 0);
    chk("rst_esc", 32'(ex_esc), 0);
    chk("rst_tk", 32'(ex_tk), 0);
    chk("rst_ban", 32'(ban), 0);
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_discard", 32'(ex_valido), 0);
    end

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 63) == 0);
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      set_ins($urandom_range(0, 3) != 0,
              ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom,
              ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom,
              4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
              3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));
      wb_esc = $urandom_range(0, 1) == 1;
      wb_rd  = 4'($urandom_range(0, 3));
      wb_res = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/etapa_ejecucion.md
# etapa_ejecucion

Execute stage of the pipelined CPU: holds the ID/EX pipeline register, forwards operands from later stages, drives the existing `UnidadLogicoAritmetica` ALU, and keeps the architectural flag register (N, Z, V, C). It evaluates the condition code of each instruction and drives the EX/MEM pipeline register consumed by the memory stage. Stall and flush come from the hazard/control unit.

## Interface
- `N`, default 32: datapath width.
- `R`, default 4: register-index width.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold both pipeline registers and the flag register.
- `flush`  in  1  load a bubble into ID/EX.
- `id_valido`  in  1  decode stage presents an instruction.
- `id_opA`, `id_opB`  in  N  register-file operands.
- `id_rs1`, `id_rs2`  in  R  source indices of `id_opA` and `id_opB`.
- `id_rd`  in  R  destination index.
- `id_sel`  in  3  ALU operation code.
- `id_escribe`  in  1  instruction writes `id_rd`.
- `id_banderas`  in  1  instruction updates the flags.
- `id_salto`  in  1  instruction is a branch.
- `id_cond`  in  3  condition code.
- `wb_escribe`  in  1  write-back stage writes a register.
- `wb_rd`  in  R  write-back destination index.
- `wb_resultado`  in  N  write-back data.
- `ex_valido`  out  1  EX/MEM holds an instruction.
- `ex_resultado`  out  N  registered ALU result.
- `ex_rd`  out  R  registered destination index.
- `ex_escribe`  out  1  registered `valido & escribe & cond_ok`.
- `ex_salto_tomado`  out  1  registered `valido & salto & cond_ok`.
- `banderas`  out  4  flag register {N, Z, V, C}.

## Operation
- ALU `Sel` codes:
  - 000 suma, 001 resta, 010 multiplicacion, 011 modulo, 100 desplazamiento derecha, 101 pass B, 110 pass A.
  - 111 is reserved; whatever the ALU outputs is passed through unchanged.
- Operand forwarding, resolved per operand from the registered rs index in EX:
  - First priority: EX/MEM, when `ex_valido & ex_escribe & ex_rd == rs`. Use `ex_resultado`.
  - Second priority: WB, when `wb_escribe & wb_rd == rs`. Use `wb_resultado`.
  - Otherwise use the registered ID/EX operand.
  - Index 0 gets no special treatment.
- Condition `cond_ok`, evaluated against the current `banderas`:
  - 000 always, 001 Z, 010 !Z, 011 N^V, 100 !(N^V), 101 C, 110 !C, 111 never.
- Flag register update:
  - Loads the four ALU flags when the EX instruction is valid, `banderas_en & cond_ok`, and `stall` is low.
  - Otherwise it holds.
- Flags seen by the next instruction: the next instruction in EX sees the updated flags without forwarding.
- Bubble handling: an invalid EX slot writes EX/MEM with `valido=0` and `escribe=0`, `salto_tomado=0`. `resultado` and `rd` may be anything.

## Timing
- Reset values: all registers clear on reset; every output reads 0 after the first edge with `rst=1`, including `banderas=4'b0000`.
- Reset mid-operation: reset overrides `stall` and `flush`, and discards in-flight instructions.
- Latency: inputs sampled at edge k appear on `ex_*` after edge k+1, i.e. 2 cycles.
- Throughput: one instruction per cycle when `stall` is low.
- `stall=1`:
  - ID/EX, EX/MEM and `banderas` hold.
  - Decode inputs are not consumed.
  - Forwarding uses the held EX/MEM content.
- `flush=1`: ID/EX loads a bubble at the edge; EX/MEM advances normally unless stalled.
- `stall` and `flush` together: ID/EX takes the bubble (flush wins); EX/MEM and `banderas` hold.
- `ex_salto_tomado`: asserted for exactly one cycle per taken branch unless stalled. The control unit responds by asserting `flush`.

## Structure
- Shared package `cpu_pkg`:
  - ALU op-code constants `ALU_SUMA` … `ALU_PASA_A`.
  - Condition constants `COND_SIEMPRE` … `COND_NUNCA`.
  - Flag bit positions.
  - A packed struct type for the ID/EX register and one for the EX/MEM register.
- Natural sub-module: `evaluador_condicion`, combinational, mapping (`cond`, `banderas`) to `cond_ok`.
- The ALU is instantiated as-is.

## Test plan
- Sum plus flags: opA=5, opB=7, sel=000, banderas_en=1 → two cycles later `ex_resultado=12`, `banderas=0000`. Then 5−5 with sel=001 → `banderas` Z=1.
- EX forwarding: back-to-back rd=3 ← 2+2, then r3+1 with stale `id_opA=0` → second result is 5. With WB-only match (`wb_rd=3`, `wb_resultado=9`) → result is 10.
- Conditional execution: flags Z=1, instruction cond=010 with escribe=1, banderas_en=1 → `ex_escribe=0` and `banderas` unchanged. Same instruction with cond=001 → `ex_escribe=1`.
- Branch: cond=011 with N=1, V=0 and salto=1 → `ex_salto_tomado=1` for one cycle. With N=1, V=1 → 0.
- Stall/flush: `stall` held 3 cycles → `ex_*` and `banderas` stable. `stall` and `flush` together → after release, one bubble appears (`ex_valido=0`).
- Reset mid-stream: `rst` asserted with 2 valid instructions in flight → next cycle all outputs 0 and none of those instructions ever appear.
